ram_loader: RTL and testbench
=============================

RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 Parameter MAX_WORDS, default 1024: word capacity of the attached RAM; legal range 1..65536.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a load; honoured only in IDLE or DONE.
REQ-005 byte_valid  input  1  upstream byte present.
REQ-006 byte_data  input  8  upstream byte.
REQ-007 byte_last  input  1  qualifies the final byte of the image; sampled with byte_valid.
REQ-008 byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 address  output  16  RAM word address.
REQ-010 data  output  32  RAM write data.
REQ-011 wren  output  1  RAM write enable; RAM writes on the rising edge.
REQ-012 q  input  32  RAM read data; combinational from address, same cycle.
REQ-013 busy  output  1  high in RECV, WRITE and READBACK.
REQ-014 done  output  1  high in DONE.
REQ-015 error  output  1  valid while done=1: overflow or readback mismatch.
REQ-016 word_count  output  17  number of words written in the current or last load.
REQ-017 checksum  output  32  modulo-2^32 sum of all words written.

Function
REQ-018 States are IDLE, RECV, WRITE, READBACK and DONE.
REQ-019 IDLE/DONE: on start, clear word_count, checksum, error and the byte index, then enter RECV.
REQ-020 RECV: byte_ready=1; a byte transfers when byte_valid and byte_ready are both high.
REQ-021 Byte k of a word (k=0..3) lands in bits [8k+7:8k] (little-endian packing).
REQ-022 Acceptance of the 4th byte, or of any byte with byte_last=1, moves to WRITE on the next cycle; the unfilled upper bytes of a partial word are zero.
REQ-023 WRITE lasts exactly one cycle: wren=1, address=word_count, data=assembled word; word_count increments and checksum adds the word on that edge.
REQ-024 From WRITE: if last was seen, go to READBACK; else if the incremented word_count equals MAX_WORDS, set error and go to DONE; else go to RECV with the byte index cleared.
REQ-025 byte_ready=0 in every state except RECV; byte_valid is ignored outside RECV.
REQ-026 READBACK: wren=0, address steps 0..word_count-1, one word per cycle, and q is summed into a separate accumulator.
REQ-027 After the final readback word, error is set if the readback sum differs from checksum, and the block enters DONE.
REQ-028 DONE holds done, error, word_count and checksum stable until start or reset.
REQ-029 Outside WRITE, wren=0 and data=0; in IDLE and DONE, address=0.
REQ-030 start is ignored while busy=1.
REQ-031 A byte_last delivered as byte 3 produces exactly one write, with no extra zero word.

Reset
REQ-032 On reset the block SHALL enter IDLE on the next edge and hold the following output values: byte_ready=0, wren=0, address=0, data=0, busy=0, done=0, error=0, word_count=0, checksum=0.
REQ-033 Reset asserted mid-load SHALL abort the load the same edge with no further writes; memory contents already written are undefined to the loader.

Structure
REQ-034 A shared package SHALL hold the state enumeration, the WORD_W=32 and ADDR_W=16 constants, and the byte-lane count of 4.
REQ-035 One sub-module, ram_loader_packer, SHALL hold the byte-to-word assembly (byte index, lane register and the full/last indication); the FSM, counters and checksums SHALL stay in ram_loader.

Verification
REQ-036 Stream bytes 01 02 03 04 05 06 07 08, with last on 08 -> writes 0x04030201@0 and 0x08070605@1; done=1, error=0, word_count=2, checksum=0x0C0A0806.
REQ-037 Stream bytes AA BB CC, with last on CC -> one write of 0x00CCBBAA@0; word_count=1, error=0.
REQ-038 With MAX_WORDS=2, stream 12 bytes and no last -> exactly two writes; error=1, done=1, word_count=2, and byte_ready=0 from then on.
REQ-039 Bench RAM model corrupts word 1 on readback -> done=1, error=1, and checksum equals the written sum.
REQ-040 Assert reset during the 3rd byte of word 1 -> all outputs take their reset values next cycle; a fresh start and 4-byte load then writes only @0.
REQ-041 Drive byte_valid with random gaps and assert start while busy -> written words are unchanged and start has no effect.

Source files
------------

// File: rtl/ram_loader_pkg.sv
// ram_loader_pkg: shared states and widths for the byte-stream RAM loader.
package ram_loader_pkg;
    localparam int WORD_W = 32;
    localparam int ADDR_W = 16;
    localparam int LANES  = 4;
    localparam int IDX_W  = $clog2(LANES);
    typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_READBACK, S_DONE} state_e;
endpackage

// File: rtl/ram_loader_packer.sv
// ram_loader_packer: assembles little-endian bytes into one RAM word.
module ram_loader_packer import ram_loader_pkg::*; (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              take_i,
    input  logic [7:0]        byte_i,
    input  logic              last_i,
    output logic [WORD_W-1:0] word_o,
    output logic              full_o,
    output logic              last_o
);
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              last_q, last_d;

    always_comb begin
        word_d = word_q;
        if (take_i) word_d[idx_q*8 +: 8] = byte_i;
        idx_d  = take_i ? idx_q + 1'b1 : idx_q;
        last_d = last_q | (take_i & last_i);
        full_o = take_i & ((idx_q == IDX_W'(LANES - 1)) | last_i);
    end

    // Clearing zeroes the word so a short final word has zero upper lanes.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            idx_q  <= '0;
            word_q <= '0;
            last_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
            last_q <= last_d;
        end
    end

    assign word_o = word_q;
    assign last_o = last_q;
endmodule

// File: rtl/ram_loader.sv
// ram_loader: streams bytes into a word RAM, then reads it back to verify the sum.
module ram_loader import ram_loader_pkg::*; #(
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    input  logic              byte_last_i,
    output logic              byte_ready_o,
    output logic [ADDR_W-1:0] address_o,
    output logic [WORD_W-1:0] data_o,
    output logic              wren_o,
    input  logic [WORD_W-1:0] q_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [ADDR_W:0]   word_count_o,
    output logic [WORD_W-1:0] checksum_o
);
    state_e            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [WORD_W-1:0] sum_q, sum_d, rb_sum_q, rb_sum_d;
    logic [ADDR_W-1:0] rb_addr_q, rb_addr_d;
    logic              err_q, err_d;
    logic [WORD_W-1:0] word;
    logic              full, last_seen, at_max, rb_final;

    ram_loader_packer u_packer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (state_q != S_RECV),
        .take_i  (byte_valid_i && state_q == S_RECV),
        .byte_i  (byte_data_i),
        .last_i  (byte_last_i),
        .word_o  (word),
        .full_o  (full),
        .last_o  (last_seen)
    );

    assign at_max   = (count_q + 1'b1) == (ADDR_W + 1)'(MAX_WORDS);
    assign rb_final = ({1'b0, rb_addr_q} + 1'b1) == count_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        sum_d     = sum_q;
        rb_sum_d  = rb_sum_q;
        rb_addr_d = rb_addr_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE, S_DONE: if (start_i) begin
                state_d   = S_RECV;
                count_d   = '0;
                sum_d     = '0;
                rb_sum_d  = '0;
                rb_addr_d = '0;
                err_d     = 1'b0;
            end
            S_RECV: state_d = full ? S_WRITE : S_RECV;
            S_WRITE: begin
                count_d = count_q + 1'b1;
                sum_d   = sum_q + word;
                err_d   = !last_seen && at_max;
                state_d = last_seen ? S_READBACK : at_max ? S_DONE : S_RECV;
            end
            S_READBACK: begin
                rb_sum_d  = rb_sum_q + q_i;
                rb_addr_d = rb_addr_q + 1'b1;
                err_d     = rb_final && (rb_sum_q + q_i != sum_q);
                state_d   = rb_final ? S_DONE : S_READBACK;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            sum_q     <= '0;
            rb_sum_q  <= '0;
            rb_addr_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            sum_q     <= sum_d;
            rb_sum_q  <= rb_sum_d;
            rb_addr_q <= rb_addr_d;
            err_q     <= err_d;
        end
    end

    assign byte_ready_o = state_q == S_RECV;
    assign wren_o       = state_q == S_WRITE;
    assign data_o       = wren_o ? word : '0;
    assign address_o    = wren_o ? count_q[ADDR_W-1:0] : state_q == S_READBACK ? rb_addr_q : '0;
    assign busy_o       = state_q inside {S_RECV, S_WRITE, S_READBACK};
    assign done_o       = state_q == S_DONE;
    assign error_o      = err_q;
    assign word_count_o = count_q;
    assign checksum_o   = sum_q;
endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: scoreboard bench with a RAM model for two loader instances.
module tb_ram_loader;
    logic        clk = 0, rst = 1;
    logic        start = 0, valid = 0, last = 0, corrupt = 0;
    logic [7:0]  bdata = 0;
    logic        ready, wren, busy, done, error;
    logic [15:0] address;
    logic [31:0] data, q, checksum;
    logic [16:0] count;
    logic        s_start = 0, s_valid = 0;
    logic [7:0]  s_data = 0;
    logic        s_ready, s_wren, s_busy, s_done, s_error;
    logic [15:0] s_address;
    logic [31:0] s_wdata, s_q, s_checksum;
    logic [16:0] s_count;
    logic [31:0] mem [0:1023];
    logic [31:0] s_mem [0:3];
    logic [47:0] exp_q [$];
    logic [47:0] exp_s [$];
    int n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    ram_loader u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .byte_valid_i(valid),
        .byte_data_i(bdata), .byte_last_i(last), .byte_ready_o(ready),
        .address_o(address), .data_o(data), .wren_o(wren), .q_i(q),
        .busy_o(busy), .done_o(done), .error_o(error),
        .word_count_o(count), .checksum_o(checksum)
    );

    ram_loader #(.MAX_WORDS(2)) u_small (
        .clk_i(clk), .rst_i(rst), .start_i(s_start), .byte_valid_i(s_valid),
        .byte_data_i(s_data), .byte_last_i(1'b0), .byte_ready_o(s_ready),
        .address_o(s_address), .data_o(s_wdata), .wren_o(s_wren), .q_i(s_q),
        .busy_o(s_busy), .done_o(s_done), .error_o(s_error),
        .word_count_o(s_count), .checksum_o(s_checksum)
    );

    // Corruption flips the low byte of word 1 only on the read path.
    assign q   = (corrupt && address == 16'd1) ? mem[address[9:0]] ^ 32'h0000_00FF : mem[address[9:0]];
    assign s_q = s_mem[s_address[1:0]];

    always @(posedge clk) begin
        if (wren) mem[address[9:0]] <= data;
        if (s_wren) s_mem[s_address[1:0]] <= s_wdata;
    end

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wren) begin
            if (exp_q.size() == 0) check("unexpected_write", {address, data}, 48'h0);
            else check("write", {address, data}, exp_q.pop_front());
        end
        if (s_wren) begin
            if (exp_s.size() == 0) check("unexpected_small_write", {s_address, s_wdata}, 48'h0);
            else check("small_write", {s_address, s_wdata}, exp_s.pop_front());
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic do_start;
        start = 1; tick(); start = 0;
    endtask

    task automatic send(input logic [7:0] d, input logic l, input int gap, input logic poke);
        logic acc;
        for (int i = 0; i < gap; i++) begin
            start = poke; tick(); start = 0;
        end
        valid = 1; bdata = d; last = l; acc = 0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk); acc = ready;
            tick();
        end
        if (!acc) check("byte_accept_timeout", 0, 1);
        valid = 0; last = 0;
    endtask

    task automatic wait_done;
        logic d = 0;
        for (int i = 0; i < 200 && !d; i++) begin
            @(negedge clk); d = done;
        end
        check("done", done, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_ready"}, ready, 0);
        check({tag, "_wren_addr_data"}, {wren, address, data}, 0);
        check({tag, "_busy_done_error"}, {busy, done, error}, 0);
        check({tag, "_count"}, count, 0);
        check({tag, "_checksum"}, checksum, 0);
    endtask

    initial begin
        int idx;
        logic acc;
        tick(); tick();
        check_reset_outputs("reset");
        rst = 0; tick();

        exp_q.push_back({16'd0, 32'h0403_0201});
        exp_q.push_back({16'd1, 32'h0807_0605});
        do_start();
        for (int i = 1; i <= 8; i++) send(8'(i), i == 8, 0, 0);
        wait_done();
        check("two_word_error", error, 0);
        check("two_word_count", count, 2);
        check("two_word_checksum", checksum, 32'h0C0A_0806);
        check("two_word_ready_busy", {ready, busy}, 0);

        exp_q.push_back({16'd0, 32'h00CC_BBAA});
        do_start();
        send(8'hAA, 0, 0, 0); send(8'hBB, 0, 0, 0); send(8'hCC, 1, 0, 0);
        wait_done();
        check("partial_count", count, 1);
        check("partial_error", error, 0);
        check("partial_checksum", checksum, 32'h00CC_BBAA);

        exp_q.push_back({16'd0, 32'h4433_2211});
        do_start();
        send(8'h11, 0, 0, 0); send(8'h22, 0, 0, 0); send(8'h33, 0, 0, 0); send(8'h44, 1, 0, 0);
        wait_done();
        check("last_on_byte3_count", count, 1);
        check("last_on_byte3_error", error, 0);

        corrupt = 1;
        exp_q.push_back({16'd0, 32'h0403_0201});
        exp_q.push_back({16'd1, 32'h0807_0605});
        do_start();
        for (int i = 1; i <= 8; i++) send(8'(i), i == 8, 0, 0);
        wait_done();
        check("corrupt_error", error, 1);
        check("corrupt_checksum", checksum, 32'h0C0A_0806);
        repeat (3) tick();
        check("done_hold", {done, error, count}, {1'b1, 1'b1, 17'd2});
        corrupt = 0;

        exp_q.push_back({16'd0, 32'h0403_0201});
        do_start();
        for (int i = 1; i <= 6; i++) send(8'(i), 0, 0, 0);
        valid = 1; bdata = 8'h07; rst = 1; tick();
        rst = 0; valid = 0;
        check_reset_outputs("midload_reset");
        exp_q.push_back({16'd0, 32'h5A5A_5A5A});
        do_start();
        for (int i = 0; i < 4; i++) send(8'h5A, i == 3, 0, 0);
        wait_done();
        check("after_reset_count", count, 1);
        check("after_reset_error", error, 0);

        exp_q.push_back({16'd0, 32'hEFBE_ADDE});
        exp_q.push_back({16'd1, 32'h0000_0001});
        do_start();
        send(8'hDE, 0, 2, 1); send(8'hAD, 0, 1, 1); send(8'hBE, 0, 3, 1);
        send(8'hEF, 0, 0, 0); send(8'h01, 1, 2, 1);
        wait_done();
        check("gap_count", count, 2);
        check("gap_checksum", checksum, 32'hEFBE_ADDF);
        check("gap_error", error, 0);

        exp_s.push_back({16'd0, 32'h0403_0201});
        exp_s.push_back({16'd1, 32'h0807_0605});
        s_start = 1; tick(); s_start = 0;
        idx = 0; s_valid = 1; s_data = 8'd1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); acc = s_ready;
            tick();
            if (acc) begin
                idx++;
                s_data = 8'(idx + 1);
                if (idx == 12) s_valid = 0;
            end
        end
        @(negedge clk);
        check("overflow_done_error", {s_done, s_error}, 2'b11);
        check("overflow_count", s_count, 2);
        check("overflow_ready", s_ready, 0);
        check("overflow_accepted", idx, 8);
        s_valid = 0;

        check("pending_writes", exp_q.size() + exp_s.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
